// File: rtl/linear_systolic_hadamard4pt.sv
// 4-point Walsh-Hadamard transform: four add/subtract PEs in a linear systolic chain,
// fed one latched sample per cycle, emitting Y0..Y3 serially on a registered output.
`timescale 1ns/1ps
module linear_systolic_hadamard4pt (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [8:0]  x0,
  input  logic signed [8:0]  x1,
  input  logic signed [8:0]  x2,
  input  logic signed [8:0]  x3,
  output logic signed [11:0] y0
);

  typedef enum logic [1:0] {ARMED = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Sylvester H4 entry is negative when the row/column index overlap has odd parity.
  function automatic logic h4_neg(input logic [1:0] row, input logic [1:0] col);
    return ^(row & col);
  endfunction

  state_t             state_r, state_s;
  logic        [3:0]  cnt_r;
  logic signed [11:0] xr_r      [4];
  logic signed [11:0] pipe_r    [3];
  logic signed [11:0] acc_r     [4];
  logic signed [11:0] feed_s;
  logic signed [11:0] pe_in_s   [4];
  logic signed [11:0] acc_nxt_s [4];
  logic        [3:0]  pe_act_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ARMED;
    else        state_r <= state_s;
  end

  // Next-state logic: start low always re-arms; counter value 8 ends the run.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARMED: begin
        if (start) state_s = RUN;
        else       state_s = ARMED;
      end
      RUN: begin
        if (!start)              state_s = ARMED;
        else if (cnt_r == 4'd8)  state_s = DONE;
        else                     state_s = RUN;
      end
      DONE: begin
        if (!start) state_s = ARMED;
        else        state_s = DONE;
      end
      default: state_s = ARMED;
    endcase
  end

  // Sample feed into PE0 and per-PE add/subtract; PEk is live for counter values k..k+3.
  always_comb begin
    if (cnt_r <= 4'd3) feed_s = xr_r[cnt_r[1:0]];
    else               feed_s = 12'sd0;
    pe_in_s[0] = feed_s;
    for (int k = 1; k < 4; k++) pe_in_s[k] = pipe_r[k-1];
    for (int k = 0; k < 4; k++) begin
      pe_act_s[k]  = 1'b0;
      acc_nxt_s[k] = acc_r[k];
      if (cnt_r >= 4'(k) && cnt_r <= 4'(k + 3)) begin
        pe_act_s[k] = 1'b1;
        if (h4_neg(2'(k), 2'(cnt_r - 4'(k)))) begin
          if (cnt_r == 4'(k)) acc_nxt_s[k] = -pe_in_s[k];
          else                acc_nxt_s[k] = acc_r[k] - pe_in_s[k];
        end else begin
          if (cnt_r == 4'(k)) acc_nxt_s[k] = pe_in_s[k];
          else                acc_nxt_s[k] = acc_r[k] + pe_in_s[k];
        end
      end else begin
        pe_act_s[k] = 1'b0;
      end
    end
  end

  // Datapath: latch, stream, accumulate, and unload finished sums onto y0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
      y0    <= 12'sd0;
      for (int k = 0; k < 4; k++) begin
        xr_r[k]  <= 12'sd0;
        acc_r[k] <= 12'sd0;
      end
      for (int k = 0; k < 3; k++) pipe_r[k] <= 12'sd0;
    end else if (!start) begin
      // Abort/re-arm: y0 deliberately keeps its last coefficient.
      cnt_r <= 4'd0;
      for (int k = 0; k < 4; k++) acc_r[k] <= 12'sd0;
      for (int k = 0; k < 3; k++) pipe_r[k] <= 12'sd0;
    end else if (state_r == ARMED) begin
      cnt_r   <= 4'd0;
      xr_r[0] <= {{3{x0[8]}}, x0};
      xr_r[1] <= {{3{x1[8]}}, x1};
      xr_r[2] <= {{3{x2[8]}}, x2};
      xr_r[3] <= {{3{x3[8]}}, x3};
    end else if (state_r == RUN) begin
      if (cnt_r != 4'd8) cnt_r <= cnt_r + 4'd1;
      else               cnt_r <= cnt_r;
      pipe_r[0] <= feed_s;
      pipe_r[1] <= pipe_r[0];
      pipe_r[2] <= pipe_r[1];
      for (int k = 0; k < 4; k++) begin
        if (pe_act_s[k]) acc_r[k] <= acc_nxt_s[k];
      end
      if (cnt_r >= 4'd4 && cnt_r <= 4'd7) y0 <= acc_r[cnt_r[1:0]];
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_linear_systolic_hadamard4pt.sv
// Self-checking bench: directed and random frames compared against an arithmetic H4 model.
`timescale 1ns/1ps
module tb_linear_systolic_hadamard4pt;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [8:0]  x0 = 9'sd0, x1 = 9'sd0, x2 = 9'sd0, x3 = 9'sd0;
  logic signed [11:0] y0;

  int n_checks = 0;
  int n_pass   = 0;
  int held     = 0;   // value y0 is expected to hold between frames

  linear_systolic_hadamard4pt dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .y0(y0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference transform straight from the Sylvester-order definition.
  function automatic void model(input int a, input int b, input int c, input int d, output int y[4]);
    y[0] = a + b + c + d;
    y[1] = a - b + c - d;
    y[2] = a + b - c - d;
    y[3] = a - b - c + d;
  endfunction

  task automatic rand_x();
    x0 = 9'($urandom); x1 = 9'($urandom); x2 = 9'($urandom); x3 = 9'($urandom);
  endtask

  // One full frame: start is expected low on entry; leaves start low after one re-arm cycle.
  task automatic frame(input string tag, input int a, input int b, input int c, input int d,
                       input bit perturb);
    int y[4];
    model(a, b, c, d, y);
    x0 = 9'(a); x1 = 9'(b); x2 = 9'(c); x3 = 9'(d);
    start = 1'b1;
    tick();                                   // E1
    for (int e = 2; e <= 9; e++) begin
      if (perturb) rand_x();
      tick();
      if (e < 6) check({tag, "_pre"}, int'(y0), held);
      else       check($sformatf("%s_Y%0d", tag, e - 6), int'(y0), y[e-6]);
    end
    held = y[3];
    for (int e = 10; e <= 12; e++) tick();
    check({tag, "_hold"}, int'(y0), held);
    start = 1'b0;
    tick();
    check({tag, "_rearm"}, int'(y0), held);
  endtask

  initial begin
    #12;
    check("reset_y0", int'(y0), 0);
    rst_n = 1'b1;
    #1;

    frame("tp1", 3, 4, -2, 1, 1'b0);
    frame("tp2", -1, 6, 2, 4, 1'b0);
    frame("tp3", 5, -3, 1, 0, 1'b0);
    frame("tp4", -2, -3, -1, -5, 1'b0);
    frame("min", -256, -256, -256, -256, 1'b0);
    frame("alt", 255, -256, 255, -256, 1'b0);
    frame("max", 255, 255, 255, 255, 1'b0);
    frame("perturb", 7, -100, 33, -9, 1'b1);

    for (int i = 0; i < 6; i++) begin
      logic signed [8:0] r [4];
      for (int j = 0; j < 4; j++) r[j] = 9'($urandom);
      frame($sformatf("rnd%0d", i), int'(r[0]), int'(r[1]), int'(r[2]), int'(r[3]), 1'b1);
    end

    // Abort by dropping start before E4: y0 keeps the previous Y3.
    x0 = 9'sd100; x1 = 9'sd100; x2 = 9'sd100; x3 = 9'sd100;
    start = 1'b1;
    tick(); tick(); tick();                   // E1..E3
    start = 1'b0;
    tick();
    check("abort_hold", int'(y0), held);
    tick();
    check("abort_hold2", int'(y0), held);
    frame("post_abort", -17, 42, 9, -120, 1'b0);

    // Asynchronous reset mid-frame forces y0 to zero without a clock edge.
    x0 = 9'sd50; x1 = -9'sd60; x2 = 9'sd70; x3 = -9'sd80;
    start = 1'b1;
    for (int e = 1; e <= 7; e++) tick();      // y0 now holds a new Y1
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_y0", int'(y0), 0);
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    held = 0;
    tick();
    check("rst_after", int'(y0), 0);
    frame("post_reset", 11, -22, 33, -44, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
